// File: rtl/otter_mcu_core_if.sv
// Bus bundle between the OTTER core and its instruction memory, data memory and interrupt sources.
// The core side is the master; memories and the interrupt aggregator sit on the slave side.
interface otter_mcu_core_if;
    logic [31:0] i_intrpt;
    logic [31:0] i_imem_r_data;
    logic [31:0] o_imem_addr;
    logic [31:0] i_dmem_r_data;
    logic        o_dmem_re;
    logic        o_dmem_we;
    logic [3:0]  o_dmem_sel;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_w_data;

    modport master (
        input  i_intrpt, i_imem_r_data, i_dmem_r_data,
        output o_imem_addr, o_dmem_re, o_dmem_we, o_dmem_sel, o_dmem_addr, o_dmem_w_data
    );

    modport slave (
        output i_intrpt, i_imem_r_data, i_dmem_r_data,
        input  o_imem_addr, o_dmem_re, o_dmem_we, o_dmem_sel, o_dmem_addr, o_dmem_w_data
    );
endinterface

// File: rtl/otter_mcu_core.sv
// OTTER MCU: multi-cycle RV32I core with machine-mode CSRs and one external interrupt.
// state     | meaning
// FETCH     | PC on imem address, instruction word arrives next cycle
// EXEC      | decode/execute, retire everything except loads
// WRITEBACK | extract load data from dmem, write rd, retire
module otter_mcu_core #(
    parameter logic [31:0] RESET_VEC = 32'h0
) (
    input logic              i_clk,
    input logic              i_rst,
    otter_mcu_core_if.master bus
);
    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_IMM = 7'b0010011, OP_AUIPC = 7'b0010111,
                           OP_STORE = 7'b0100011, OP_OP = 7'b0110011, OP_LUI = 7'b0110111,
                           OP_BRANCH = 7'b1100011, OP_JALR = 7'b1100111, OP_JAL = 7'b1101111,
                           OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {FETCH, EXEC, WRITEBACK} state_t;
    state_t state, state_nxt;

    logic [31:0] pc;
    logic [31:0] rf [0:31];
    logic        mstatus_mie, mstatus_mpie, mie_meie;
    logic [31:0] mtvec, mepc, mcause;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_f3;
    logic [1:0]  ld_off;

    logic [31:0] ir, imm_i, imm_s, imm_b, imm_u, imm_j, rs1_val, rs2_val, ea;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2, ld_sh, wb_rd;
    logic [2:0]  f3;
    logic [11:0] csr_addr;
    logic [31:0] csr_rdata, csr_src, csr_wval, alu_b, alu_out, ld_word, ld_val;
    logic [31:0] wb_val, pc_seq, pc_tgt;
    logic        wb_en, csr_we, is_mret, br_taken, alt, retire, irq_take;

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op, input logic sub_sra);
        logic [31:0] r;
        case (op)
            3'b000: r = sub_sra ? a - b : a + b;
            3'b001: r = a << b[4:0];
            3'b010: r = {31'b0, $signed(a) < $signed(b)};
            3'b011: r = {31'b0, a < b};
            3'b100: r = a ^ b;
            3'b101: begin
                if (sub_sra) r = $signed(a) >>> b[4:0];
                else         r = a >> b[4:0];
            end
            3'b110: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    assign ir       = bus.i_imem_r_data;
    assign opcode   = ir[6:0];
    assign rd       = ir[11:7];
    assign f3       = ir[14:12];
    assign rs1      = ir[19:15];
    assign rs2      = ir[24:20];
    assign csr_addr = ir[31:20];
    assign imm_i    = {{20{ir[31]}}, ir[31:20]};
    assign imm_s    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u    = {ir[31:12], 12'b0};
    assign imm_j    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign rs1_val  = (rs1 == 5'd0) ? 32'b0 : rf[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'b0 : rf[rs2];
    assign ea       = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign pc_seq   = pc + 32'd4;
    assign alt      = ir[30] & ((opcode == OP_OP) | (f3 == 3'b101));
    assign alu_b    = (opcode == OP_OP) ? rs2_val : imm_i;
    assign alu_out  = alu(rs1_val, alu_b, f3, alt);
    assign csr_src  = f3[2] ? {27'b0, rs1} : rs1_val;
    assign retire   = (state == EXEC && opcode != OP_LOAD) || state == WRITEBACK;
    assign irq_take = retire && (|bus.i_intrpt) && mstatus_mie && mie_meie;

    always_comb begin
        csr_rdata = 32'b0;
        case (csr_addr)
            12'h300: csr_rdata = {24'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
            12'h304: csr_rdata = {20'b0, mie_meie, 11'b0};
            12'h305: csr_rdata = mtvec;
            12'h341: csr_rdata = mepc;
            12'h342: csr_rdata = mcause;
            default: csr_rdata = 32'b0;
        endcase
    end

    always_comb begin
        case (f3[1:0])
            2'b01:   csr_wval = csr_src;
            2'b10:   csr_wval = csr_rdata | csr_src;
            default: csr_wval = csr_rdata & ~csr_src;
        endcase
        case (f3)
            3'b000:  br_taken = rs1_val == rs2_val;
            3'b001:  br_taken = rs1_val != rs2_val;
            3'b100:  br_taken = $signed(rs1_val) < $signed(rs2_val);
            3'b101:  br_taken = $signed(rs1_val) >= $signed(rs2_val);
            3'b110:  br_taken = rs1_val < rs2_val;
            3'b111:  br_taken = rs1_val >= rs2_val;
            default: br_taken = 1'b0;
        endcase
    end

    // Halves follow the same lane pairing as SH: offset 1 reads the low half, 3 the high half.
    always_comb begin
        case (ld_f3[1:0])
            2'b00:   ld_sh = {ld_off, 3'b000};
            2'b01:   ld_sh = {ld_off[1], 4'b0000};
            default: ld_sh = 5'd0;
        endcase
        ld_word = bus.i_dmem_r_data >> ld_sh;
        case (ld_f3)
            3'b000:  ld_val = {{24{ld_word[7]}}, ld_word[7:0]};
            3'b001:  ld_val = {{16{ld_word[15]}}, ld_word[15:0]};
            3'b100:  ld_val = {24'b0, ld_word[7:0]};
            3'b101:  ld_val = {16'b0, ld_word[15:0]};
            default: ld_val = ld_word;
        endcase
    end

    always_comb begin
        wb_en   = 1'b0;
        wb_rd   = rd;
        wb_val  = 32'b0;
        pc_tgt  = pc_seq;
        csr_we  = 1'b0;
        is_mret = 1'b0;
        if (state == EXEC) begin
            case (opcode)
                OP_OP, OP_IMM: begin wb_en = 1'b1; wb_val = alu_out; end
                OP_LUI:        begin wb_en = 1'b1; wb_val = imm_u; end
                OP_AUIPC:      begin wb_en = 1'b1; wb_val = pc + imm_u; end
                OP_JAL:        begin wb_en = 1'b1; wb_val = pc_seq; pc_tgt = pc + imm_j; end
                OP_JALR:       begin wb_en = 1'b1; wb_val = pc_seq; pc_tgt = ea & ~32'h1; end
                OP_BRANCH:     if (br_taken) pc_tgt = pc + imm_b;
                OP_SYSTEM: begin
                    if (f3[1:0] == 2'b00) begin
                        if (ir == 32'h30200073) begin
                            is_mret = 1'b1;
                            pc_tgt  = mepc;
                        end
                    end else begin
                        wb_en  = 1'b1;
                        wb_val = csr_rdata;
                        csr_we = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (state == WRITEBACK) begin
            wb_en  = 1'b1;
            wb_rd  = ld_rd;
            wb_val = ld_val;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:     state_nxt = EXEC;
            EXEC:      state_nxt = (opcode == OP_LOAD) ? WRITEBACK : FETCH;
            WRITEBACK: state_nxt = FETCH;
            default:   state_nxt = FETCH;
        endcase
    end

    always_comb begin
        bus.o_imem_addr   = pc;
        bus.o_dmem_re     = (state == EXEC) && (opcode == OP_LOAD);
        bus.o_dmem_we     = (state == EXEC) && (opcode == OP_STORE);
        bus.o_dmem_sel    = 4'b0;
        bus.o_dmem_addr   = 32'b0;
        bus.o_dmem_w_data = 32'b0;
        if (bus.o_dmem_re || bus.o_dmem_we) begin
            bus.o_dmem_addr = {ea[31:2], 2'b00};
            case (f3[1:0])
                2'b00:   bus.o_dmem_sel = 4'b0001 << ea[1:0];
                2'b01:   bus.o_dmem_sel = 4'b0011 << {ea[1], 1'b0};
                default: bus.o_dmem_sel = 4'b1111;
            endcase
        end
        if (bus.o_dmem_we) begin
            case (f3[1:0])
                2'b00:   bus.o_dmem_w_data = {4{rs2_val[7:0]}};
                2'b01:   bus.o_dmem_w_data = {2{rs2_val[15:0]}};
                default: bus.o_dmem_w_data = rs2_val;
            endcase
        end
    end

    // Interrupt entry is assigned last so it overrides any CSR write by the retiring instruction.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pc           <= RESET_VEC;
            for (int i = 0; i < 32; i++) rf[i] <= 32'b0;
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_meie     <= 1'b0;
            mtvec        <= 32'b0;
            mepc         <= 32'b0;
            mcause       <= 32'b0;
            ld_rd        <= 5'd0;
            ld_f3        <= 3'd0;
            ld_off       <= 2'd0;
        end else begin
            if (state == EXEC && opcode == OP_LOAD) begin
                ld_rd  <= rd;
                ld_f3  <= f3;
                ld_off <= ea[1:0];
            end
            if (wb_en && wb_rd != 5'd0) rf[wb_rd] <= wb_val;
            if (retire) pc <= irq_take ? {mtvec[31:2], 2'b00} : pc_tgt;
            if (csr_we) begin
                case (csr_addr)
                    12'h300: begin mstatus_mie <= csr_wval[3]; mstatus_mpie <= csr_wval[7]; end
                    12'h304: mie_meie <= csr_wval[11];
                    12'h305: mtvec <= csr_wval;
                    12'h341: mepc <= csr_wval;
                    12'h342: mcause <= csr_wval;
                    default: ;
                endcase
            end
            if (is_mret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end
            if (irq_take) begin
                mepc         <= pc_tgt;
                mcause       <= 32'h8000000B;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_otter_mcu_core.sv
// Directed bench for otter_mcu_core: fetch timing, ALU/branch/jump/load/store results observed on the
// store port, interrupt entry/return, and reset aborting a load or a store.
module tb_otter_mcu_core;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic const_mode = 1'b1;
    logic trace_on = 1'b0;
    logic [31:0] imem [0:127];
    int n_checks = 0, n_pass = 0;
    int st_idx = 0, re_cnt = 0, idle_bad = 0;
    logic [31:0] tr[$], exp_tr[$];
    int dw[$];
    logic [31:0] st_a[$], st_d[$];
    logic [3:0]  st_s[$];

    localparam logic [6:0] OPI = 7'h13, LD = 7'h03, LUI = 7'h37, AUIPC = 7'h17, SYS = 7'h73, JALR = 7'h67;

    otter_mcu_core_if bus();
    otter_mcu_core dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.i_imem_r_data <= const_mode ? 32'h82f7b013 : imem[bus.o_imem_addr[8:2]];
        bus.i_dmem_r_data <= 32'h0000_8000;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
        logic [11:0] im;
        im = imm[11:0];
        return {im, rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        logic [11:0] im;
        im = imm[11:0];
        return {im[11:5], rs2[4:0], rs1[4:0], f3[2:0], im[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [12:0] im;
        im = imm[12:0];
        return {im[12], im[10:5], rs2[4:0], rs1[4:0], f3[2:0], im[4:1], im[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] enc_u(int imm20, int rd, logic [6:0] op);
        return {imm20[19:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [20:0] im;
        im = imm[20:0];
        return {im[20], im[10:1], im[11], im[19:12], rd[4:0], 7'h6F};
    endfunction

    task automatic put(input int addr, input logic [31:0] w);
        imem[addr >> 2] = w;
    endtask
    task automatic exp_st(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        st_a.push_back(a); st_s.push_back(s); st_d.push_back(d);
    endtask
    task automatic wait_addr(input logic [31:0] a, input int budget, input string tag);
        int n;
        n = 0;
        while (bus.o_imem_addr !== a && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, bus.o_imem_addr, a);
    endtask

    // Fetch trace, load-strobe count, store scoreboard and idle-output monitor.
    always @(negedge clk) begin
        if (rst) begin
            if (trace_on) begin
                if (tr.size() == 0 || bus.o_imem_addr != tr[tr.size()-1]) begin
                    tr.push_back(bus.o_imem_addr);
                    dw.push_back(1);
                end else begin
                    dw[dw.size()-1] = dw[dw.size()-1] + 1;
                end
                if (bus.o_dmem_re) re_cnt++;
            end
            if (bus.o_dmem_we) begin
                if (st_idx < st_a.size()) begin
                    chk($sformatf("st%0d_addr", st_idx), bus.o_dmem_addr, st_a[st_idx]);
                    chk($sformatf("st%0d_sel", st_idx), {28'b0, bus.o_dmem_sel}, {28'b0, st_s[st_idx]});
                    chk($sformatf("st%0d_data", st_idx), bus.o_dmem_w_data, st_d[st_idx]);
                end else begin
                    chk("st_extra", bus.o_dmem_addr, 32'hFFFF_FFFF);
                end
                st_idx++;
            end else if (!bus.o_dmem_re &&
                         (bus.o_dmem_sel != 4'b0 || bus.o_dmem_addr != 32'b0 || bus.o_dmem_w_data != 32'b0)) begin
                idle_bad++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_intrpt = 32'b0;
        for (int i = 0; i < 128; i++) imem[i] = 32'h0000_0013;

        // Constant SLTIU x0 instruction: pure fetch cadence.
        repeat (5) @(negedge clk);
        chk("rst_imem_addr", bus.o_imem_addr, 32'h0);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("p1_addr%0d", k), bus.o_imem_addr, (k / 2) * 4);
            chk($sformatf("p1_strb%0d", k), {30'b0, bus.o_dmem_re, bus.o_dmem_we}, 32'b0);
            @(negedge clk);
        end

        #2 rst = 1'b0;
        const_mode = 1'b0;
        put('h00, 32'h82f7b013);             exp_st('h40, 4'hF, 32'h0);
        put('h04, enc_s(64, 0, 0, 2));
        put('h08, enc_i(90, 0, 0, 1, OPI));
        put('h0C, enc_s(3, 1, 0, 0));        exp_st('h00, 4'b1000, 32'h5A5A5A5A);
        put('h10, enc_i(1, 0, 0, 2, LD));
        put('h14, enc_s(4, 2, 0, 2));        exp_st('h04, 4'hF, 32'hFFFFFF80);
        put('h18, enc_i(1, 0, 4, 3, LD));
        put('h1C, enc_s(6, 3, 0, 1));        exp_st('h04, 4'b1100, 32'h00800080);
        put('h20, enc_i(-3, 0, 0, 4, OPI));
        put('h24, enc_r('h20, 4, 1, 0, 5));
        put('h28, enc_s(8, 5, 0, 2));        exp_st('h08, 4'hF, 32'h5D);
        put('h2C, enc_r(0, 1, 4, 2, 6));
        put('h30, enc_s(12, 6, 0, 2));       exp_st('h0C, 4'hF, 32'h1);
        put('h34, enc_r(0, 1, 4, 3, 7));
        put('h38, enc_s(16, 7, 0, 2));       exp_st('h10, 4'hF, 32'h0);
        put('h3C, enc_i('h401, 4, 5, 8, OPI));
        put('h40, enc_s(20, 8, 0, 2));       exp_st('h14, 4'hF, 32'hFFFFFFFE);
        put('h44, enc_i(33, 0, 0, 9, OPI));
        put('h48, enc_r(0, 9, 1, 1, 10));
        put('h4C, enc_s(24, 10, 0, 2));      exp_st('h18, 4'hF, 32'hB4);
        put('h50, enc_u('h12345, 11, LUI));
        put('h54, enc_r(0, 4, 11, 4, 11));
        put('h58, enc_s(28, 11, 0, 2));      exp_st('h1C, 4'hF, 32'hEDCBAFFD);
        put('h5C, enc_u(1, 12, AUIPC));
        put('h60, enc_s(32, 12, 0, 2));      exp_st('h20, 4'hF, 32'h105C);
        put('h64, enc_b(8, 0, 0, 1));
        put('h68, enc_b(12, 0, 0, 0));
        put('h6C, enc_s(124, 1, 0, 2));
        put('h70, enc_s(124, 1, 0, 2));
        put('h74, enc_j(12, 13));
        put('h78, enc_s(36, 13, 0, 2));      exp_st('h24, 4'hF, 32'h78);
        put('h7C, enc_j(12, 0));
        put('h80, enc_b(-8, 0, 0, 0));
        put('h84, enc_s(124, 1, 0, 2));
        put('h88, enc_i(256, 0, 0, 14, OPI));
        put('h8C, enc_i('h305, 14, 1, 0, SYS));
        put('h90, enc_i(1, 0, 0, 14, OPI));
        put('h94, enc_i(11, 14, 1, 14, OPI));
        put('h98, enc_i('h304, 14, 1, 0, SYS));
        put('h9C, enc_i('h300, 8, 6, 0, SYS));
        put('hA0, enc_i('hB1, 0, 0, 0, JALR));
        put('hA4, enc_s(124, 1, 0, 2));
        put('hB0, enc_i(7, 0, 0, 16, OPI));
        put('h100, enc_i('h341, 0, 2, 19, SYS));
        put('h104, enc_s(52, 19, 0, 2));     exp_st('h34, 4'hF, 32'hB4);
        put('h108, enc_i('h342, 0, 2, 20, SYS));
        put('h10C, enc_s(56, 20, 0, 2));     exp_st('h38, 4'hF, 32'h8000000B);
        put('h110, enc_i('h300, 0, 2, 21, SYS));
        put('h114, enc_s(60, 21, 0, 2));     exp_st('h3C, 4'hF, 32'h80);
        put('h118, 32'h30200073);
        put('hB4, enc_s(40, 16, 0, 2));      exp_st('h28, 4'hF, 32'h7);
        put('hB8, enc_i('h300, 0, 2, 17, SYS));
        put('hBC, enc_s(44, 17, 0, 2));      exp_st('h2C, 4'hF, 32'h88);
        put('hC0, enc_i('h7C0, 5, 5, 18, SYS));
        put('hC4, enc_s(48, 18, 0, 2));      exp_st('h30, 4'hF, 32'h0);
        put('hC8, enc_j(0, 0));

        for (int a = 0; a <= 'h68; a += 4) exp_tr.push_back(a);
        exp_tr.push_back('h74); exp_tr.push_back('h80); exp_tr.push_back('h78); exp_tr.push_back('h7C);
        for (int a = 'h88; a <= 'hA0; a += 4) exp_tr.push_back(a);
        exp_tr.push_back('hB0);
        for (int a = 'h100; a <= 'h118; a += 4) exp_tr.push_back(a);
        for (int a = 'hB4; a <= 'hC8; a += 4) exp_tr.push_back(a);

        @(negedge clk);
        trace_on = 1'b1;
        rst = 1'b1;
        wait_addr(32'hB0, 400, "reach_B0");
        bus.i_intrpt = 32'h1;
        wait_addr(32'h100, 10, "irq_vector");
        bus.i_intrpt = 32'h0;
        wait_addr(32'hC8, 200, "reach_end");
        repeat (4) @(negedge clk);
        trace_on = 1'b0;

        chk("trace_len", tr.size(), exp_tr.size());
        for (int i = 0; i < exp_tr.size() && i < tr.size(); i++)
            chk($sformatf("trace%0d", i), tr[i], exp_tr[i]);
        if (dw.size() > 4) begin
            chk("sb_dwell", dw[3], 2);
            chk("lb_dwell", dw[4], 3);
        end else begin
            chk("dwell_entries", dw.size(), 5);
        end
        chk("re_cycles", re_cnt, 2);
        chk("p2_stores", st_idx, 18);

        // Reset during a load's WRITEBACK, then during a store's EXEC.
        #2 rst = 1'b0;
        put('h00, enc_i(0, 0, 2, 8, LD));
        @(negedge clk);
        rst = 1'b1;
        begin
            int n;
            n = 0;
            while (!bus.o_dmem_re && n < 10) begin
                @(negedge clk);
                n++;
            end
        end
        chk("p3_load_re", {31'b0, bus.o_dmem_re}, 32'h1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_imem_addr", bus.o_imem_addr, 32'h0);
        chk("abort_dmem", bus.o_dmem_addr | bus.o_dmem_w_data |
            {26'b0, bus.o_dmem_sel, bus.o_dmem_re, bus.o_dmem_we}, 32'h0);
        put('h00, enc_s(80, 8, 0, 2));       exp_st('h50, 4'hF, 32'h0);
        put('h04, enc_s(84, 0, 0, 2));       exp_st('h54, 4'hF, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_addr(32'h4, 10, "p3_reach_4");
        @(negedge clk);
        chk("p3_we_live", {31'b0, bus.o_dmem_we}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("rst_drops_we", {31'b0, bus.o_dmem_we}, 32'h0);
        repeat (2) @(negedge clk);

        chk("st_count", st_idx, 20);
        chk("idle_zero", idle_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
